// File: rtl/fixed_sqrt.sv
// Iterative unsigned fixed-point square root, one result bit per clock
// (restoring digit-by-digit), with remainder, exactness flag and optional rounding.
module fixed_sqrt #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 0,
    parameter int ROUND     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     input_a,
    input  logic                 input_a_stb,
    output logic                 input_a_ack,
    output logic [WIDTH/2-1:0]   output_z,
    output logic [WIDTH/2:0]     output_r,
    output logic                 output_exact,
    output logic                 output_z_stb,
    input  logic                 output_z_ack
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 2) ? $clog2(HALF) : 1;

    // Fractional bits only move the implied binary point; the integer datapath is unaffected.
    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4 || (FRAC_BITS % 2) != 0 || FRAC_BITS > WIDTH
            || FRAC_BITS < 0) begin : g_bad_param
            $error("fixed_sqrt: illegal WIDTH/FRAC_BITS combination");
        end
    endgenerate

    typedef enum logic [1:0] {GET_A, CALC, FINISH, PUT_Z} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [HALF-1:0]   root_q, root_d;
    logic [HALF+1:0]   rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              stb_q, stb_d;
    logic [HALF-1:0]   z_q, z_d;
    logic [HALF:0]     r_q, r_d;
    logic              exact_q, exact_d;

    logic [HALF+1:0]   rem_shift;
    logic [HALF+1:0]   trial;
    logic [HALF+1:0]   rem_sub;
    logic              take;
    logic              round_up;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        root_d    = root_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        stb_d     = stb_q;
        z_d       = z_q;
        r_d       = r_q;
        exact_d   = exact_q;

        rem_shift = {rem_q[HALF-1:0], a_q[WIDTH-1:WIDTH-2]};
        trial     = {root_q, 2'b01};
        take      = (rem_shift >= trial);
        rem_sub   = rem_shift - trial;
        // r > q means sqrt(a) >= q + 0.5 exactly; equality is impossible for integer a.
        round_up  = (ROUND != 0) && (rem_q[HALF:0] > {1'b0, root_q}) && !(&root_q);

        case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (input_a_stb && ack_q) begin
                    a_d     = input_a;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CW'(HALF - 1);
                    ack_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d    = {a_q[WIDTH-3:0], 2'b00};
                rem_d  = take ? rem_sub : rem_shift;
                root_d = {root_q[HALF-2:0], take};
                if (cnt_q == '0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FINISH: begin
                z_d     = round_up ? root_q + 1'b1 : root_q;
                r_d     = rem_q[HALF:0];
                exact_d = (rem_q == '0);
                stb_d   = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (output_z_ack) begin
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            stb_q   <= 1'b0;
            z_q     <= '0;
            r_q     <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            stb_q   <= stb_d;
            z_q     <= z_d;
            r_q     <= r_d;
            exact_q <= exact_d;
        end
    end

    assign input_a_ack  = ack_q;
    assign output_z_stb = stb_q;
    assign output_z     = z_q;
    assign output_r     = r_q;
    assign output_exact = exact_q;

endmodule

// File: tb/tb_fixed_sqrt.sv
// Directed and random checks of fixed_sqrt: truncating, rounding and fractional instances
// driven in lockstep from shared inputs.
module tb_fixed_sqrt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = '0;
    logic        input_a_stb = 1'b0;
    logic        output_z_ack = 1'b0;

    logic        ack_t, ack_r, ack_f;
    logic        stb_t, stb_r, stb_f;
    logic [15:0] z_t, z_r, z_f;
    logic [16:0] r_t, r_r, r_f;
    logic        ex_t, ex_r, ex_f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fixed_sqrt #(.WIDTH(32), .FRAC_BITS(0), .ROUND(0)) u_trunc (
        .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb),
        .input_a_ack(ack_t), .output_z(z_t), .output_r(r_t), .output_exact(ex_t),
        .output_z_stb(stb_t), .output_z_ack(output_z_ack));

    fixed_sqrt #(.WIDTH(32), .FRAC_BITS(0), .ROUND(1)) u_round (
        .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb),
        .input_a_ack(ack_r), .output_z(z_r), .output_r(r_r), .output_exact(ex_r),
        .output_z_stb(stb_r), .output_z_ack(output_z_ack));

    fixed_sqrt #(.WIDTH(32), .FRAC_BITS(16), .ROUND(0)) u_frac (
        .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb),
        .input_a_ack(ack_f), .output_z(z_f), .output_r(r_f), .output_exact(ex_f),
        .output_z_stb(stb_f), .output_z_ack(output_z_ack));

    typedef struct {
        logic [31:0] a;
        logic [15:0] zt;
        logic [16:0] r;
        logic        ex;
        logic [15:0] zr;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint isqrt(input longint a);
        longint q;
        q = longint'($sqrt(real'(a)));
        while (q * q > a) q--;
        while ((q + 1) * (q + 1) <= a) q++;
        return q;
    endfunction

    // One full transaction; hold > 0 back-pressures, hold < 0 keeps ack high before stb rises.
    task automatic do_op(input logic [31:0] a, input logic [15:0] zt, input logic [16:0] rr,
                         input logic ex, input logic [15:0] zr, input int hold);
        int n;
        n = 0;
        while (!ack_t && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", longint'(ack_t), 1);
        if (!ack_t) return;
        input_a     = a;
        input_a_stb = 1'b1;
        if (hold < 0) output_z_ack = 1'b1;
        @(negedge clk);
        input_a_stb = 1'b0;
        check("ack_drop", longint'(ack_t), 0);
        n = 0;
        while (!stb_t && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 17);
        check("stb_round", longint'(stb_r), 1);
        check("stb_frac", longint'(stb_f), 1);
        check("z_trunc", longint'(z_t), longint'(zt));
        check("r_trunc", longint'(r_t), longint'(rr));
        check("exact_trunc", longint'(ex_t), longint'(ex));
        check("z_round", longint'(z_r), longint'(zr));
        check("r_round", longint'(r_r), longint'(rr));
        check("exact_round", longint'(ex_r), longint'(ex));
        check("z_frac", longint'(z_f), longint'(zt));
        for (int i = 0; i < hold; i++) begin
            input_a     = ~a;
            input_a_stb = i[0];
            @(negedge clk);
            check("hold_stb", longint'(stb_t), 1);
            check("hold_ack", longint'(ack_t), 0);
            check("hold_z", longint'(z_r), longint'(zr));
            check("hold_r", longint'(r_t), longint'(rr));
            check("hold_exact", longint'(ex_t), longint'(ex));
        end
        input_a_stb  = 1'b0;
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        check("handback_stb", longint'(stb_t), 0);
        check("handback_ack", longint'(ack_t), 1);
        check("handback_z_kept", longint'(z_t), longint'(zt));
        $display("op a=%08h z=%0d r=%0d exact=%0d zround=%0d", a, z_t, r_t, ex_t, z_r);
    endtask

    initial begin
        vec_t vecs[13];
        logic [31:0] ra;
        longint q, rem, qr;

        vecs[0]  = '{32'd0,          16'd0,     17'd0,      1'b1, 16'd0};
        vecs[1]  = '{32'd200,        16'd14,    17'd4,      1'b0, 16'd14};
        vecs[2]  = '{32'd210,        16'd14,    17'd14,     1'b0, 16'd14};
        vecs[3]  = '{32'd211,        16'd14,    17'd15,     1'b0, 16'd15};
        vecs[4]  = '{32'd225,        16'd15,    17'd0,      1'b1, 16'd15};
        vecs[5]  = '{32'hFFFFFFFF,   16'd65535, 17'd131070, 1'b0, 16'd65535};
        vecs[6]  = '{32'h00020000,   16'd362,   17'd28,     1'b0, 16'd362};
        vecs[7]  = '{32'd144,        16'd12,    17'd0,      1'b1, 16'd12};
        vecs[8]  = '{32'd1,          16'd1,     17'd0,      1'b1, 16'd1};
        vecs[9]  = '{32'd2,          16'd1,     17'd1,      1'b0, 16'd1};
        vecs[10] = '{32'd3,          16'd1,     17'd2,      1'b0, 16'd2};
        vecs[11] = '{32'hFFFE0001,   16'd65535, 17'd0,      1'b1, 16'd65535};
        vecs[12] = '{32'hFFFE0000,   16'd65534, 17'd131068, 1'b0, 16'd65535};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ack", longint'(ack_t), 0);
        check("rst_stb", longint'(stb_t), 0);
        check("rst_z", longint'(z_t), 0);
        check("rst_r", longint'(r_t), 0);
        check("rst_exact", longint'(ex_t), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ack_after_rst", longint'(ack_t), 1);

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].a, vecs[i].zt, vecs[i].r, vecs[i].ex, vecs[i].zr, 0);

        // Back-pressure with ignored operand pulses, then ack held high early.
        do_op(32'd200, 16'd14, 17'd4, 1'b0, 16'd14, 5);
        do_op(32'd211, 16'd14, 17'd15, 1'b0, 16'd15, -1);

        // Reset mid-CALC aborts and clears every output.
        input_a     = 32'd12345;
        input_a_stb = 1'b1;
        @(negedge clk);
        input_a_stb = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_stb", longint'(stb_t), 0);
        check("abort_ack", longint'(ack_t), 0);
        check("abort_z", longint'(z_t), 0);
        check("abort_r", longint'(r_t), 0);
        check("abort_exact", longint'(ex_t), 0);
        repeat (30) begin
            @(negedge clk);
            if (stb_t) break;
        end
        check("abort_no_result", longint'(stb_t), 0);
        do_op(32'd144, 16'd12, 17'd0, 1'b1, 16'd12, 0);

        for (int k = 0; k < 100; k++) begin
            ra  = (k < 50) ? $urandom : ($urandom >> $urandom_range(0, 31));
            q   = isqrt(longint'(ra));
            rem = longint'(ra) - q * q;
            qr  = (rem > q && q < 65535) ? q + 1 : q;
            do_op(ra, q[15:0], rem[16:0], rem == 0, qr[15:0], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fixed_sqrt.md
# fixed_sqrt

Parametrised iterative square-root unit for unsigned fixed-point operands. It computes the root one result bit per clock using the restoring digit-by-digit method. Results are truncated or rounded to nearest, and each result carries its remainder and an exactness flag. It sits in the arithmetic library next to the single-precision `sqrt`, uses the same stb/ack operand and result handshake, and serves datapaths that do not need IEEE float.

## Interface
- `WIDTH`, 32: operand width; must be even and at least 4.
- `FRAC_BITS`, 0: fractional bits of the operand; must be even and at most `WIDTH`. The result has `FRAC_BITS/2` fractional bits.
- `ROUND`, 0: 0 truncates the root; 1 rounds it to nearest, saturating at all-ones.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `input_a` in `WIDTH`: operand, unsigned fixed point.
- `input_a_stb` in 1: operand valid.
- `input_a_ack` out 1: unit ready to accept an operand.
- `output_z` out `WIDTH/2`: root.
- `output_r` out `WIDTH/2+1`: remainder `a - q*q`, where `q` is the truncated root.
- `output_exact` out 1: high when `output_r == 0`.
- `output_z_stb` out 1: result valid.
- `output_z_ack` in 1: consumer has taken the result.

## Operation
- The operand is treated as the integer `A = input_a`.
- Truncated root: `q = floor(sqrt(A))`. Read with `FRAC_BITS/2` fractional bits, `q` is the fixed-point root.
- FSM states:
  - `GET_A`: `input_a_ack = 1`. An edge with `input_a_stb & input_a_ack` latches `input_a`, clears the root and remainder accumulators, loads the iteration counter with `WIDTH/2 - 1`, and moves to `CALC`.
  - `CALC`: one iteration per cycle.
    - Shift the next two operand bits (MSB pair first) into the remainder.
    - Trial value `t = {root, 2'b01}`.
    - If `remainder >= t`: `remainder -= t` and shift a 1 into the root; otherwise shift a 0 into the root.
    - After `WIDTH/2` iterations, go to `FINISH`.
  - `FINISH`: registers `output_r`, `output_exact` and `output_z`, then goes to `PUT_Z`.
    - `ROUND=0`: `output_z = q`.
    - `ROUND=1`: `output_z = q + 1` if `r > q`, else `q`. Ties cannot occur. If `q` is all-ones, `output_z` saturates at all-ones.
  - `PUT_Z`: `output_z_stb = 1`. All result outputs are held stable. An edge with `output_z_stb & output_z_ack` moves to `GET_A`.
- Remainder register width is `WIDTH/2 + 2`, so the subtract never loses a carry. `output_r` is the low `WIDTH/2 + 1` bits; the bound `r <= 2q` guarantees this fits.
- `input_a_stb` is ignored outside `GET_A`. `output_z_ack` is ignored outside `PUT_Z`.

## Timing
- While `rst` is high at a clock edge:
  - state becomes `GET_A`;
  - `input_a_ack`, `output_z_stb`, `output_exact` = 0;
  - `output_z`, `output_r` = 0;
  - internal accumulators are cleared.
- `input_a_ack` rises at the first edge after `rst` is released; it is a registered output.
- Reset asserted in any state aborts the operation at that edge. No partial result is ever presented.
- Accept edge (call it edge 0): `input_a_ack` falls after that edge.
- `CALC` occupies edges 1 through `WIDTH/2`; `FINISH` is edge `WIDTH/2 + 1`.
- `output_z_stb` is high after edge `WIDTH/2 + 1`: 17 edges after accept for `WIDTH=32`. Latency is independent of the operand value.
- Hand-back: at the edge where `output_z_stb & output_z_ack` are both high, `output_z_stb` falls and `input_a_ack` rises together. A new operand can be accepted at the following edge. Throughput is one result per `WIDTH/2 + 3` cycles minimum.
- `output_z_ack` held high across the rise of `output_z_stb` completes the transfer at the first edge where `stb` is high.
- Result outputs keep their last value after the hand-back until the next `FINISH`.
- Back-pressure: `output_z_ack` low holds `PUT_Z` indefinitely, with outputs unchanged and `input_a_ack` = 0.

## Test plan
- `WIDTH=32`, `ROUND=0`; `a=0` → z=0, r=0, exact=1. `a=200` → z=14, r=4, exact=0. Check `output_z_stb` rises exactly 17 edges after accept.
- `a=32'hFFFFFFFF`: with `ROUND=0` → z=65535, r=131070. With `ROUND=1` → z=65535 (saturated), r=131070.
- `ROUND=1`: `a=210` → z=14 (r=14); `a=211` → z=15 (r=15); `a=225` → z=15, r=0, exact=1.
- `FRAC_BITS=16`, `a=32'h00020000` (2.0) → z=16'h016A (362, i.e. 1.4140625), r=28.
- Hold `output_z_ack` low for 5 cycles after stb: z/r/exact stable, `input_a_ack` stays 0, and `input_a_stb` pulses are ignored. Then ack: stb falls and `input_a_ack` rises on the same edge.
- Assert `rst` for one cycle mid-`CALC`: all outputs go to 0 at that edge, and the next operand (`a=144`) yields z=12, r=0 with normal latency. Finish with 100 random operands checked against a reference model `floor(sqrt(a))` and `a - q*q`.
